// File: rtl/e203_exu_longpwbck_sched.sv
`default_nettype none
// ============================================================================
// Module   : e203_exu_longpwbck_sched
// Brief    : Long-pipe write-back scheduler. Accepts LSU / MULDIV results only
//            when their itag matches the OITF head, buffers them in a small
//            FIFO and routes the head to the regfile write-back port, the
//            exception port, or drops it silently when it writes nothing.
// Revision : 1.0 - initial release
// ============================================================================
module e203_exu_longpwbck_sched #(
    parameter int ITAG_W     = 1,
    parameter int FIFO_DEPTH = 2,
    parameter int STALL_MAX  = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lsu_i_valid,
    output logic                          lsu_i_ready,
    input  logic [31:0]                   lsu_i_wdat,
    input  logic [ITAG_W-1:0]             lsu_i_itag,
    input  logic                          lsu_i_err,
    input  logic                          mdv_i_valid,
    output logic                          mdv_i_ready,
    input  logic [31:0]                   mdv_i_wdat,
    input  logic [ITAG_W-1:0]             mdv_i_itag,
    input  logic                          mdv_i_err,
    input  logic                          oitf_empty,
    input  logic [ITAG_W-1:0]             oitf_ret_ptr,
    input  logic [4:0]                    oitf_ret_rdidx,
    input  logic                          oitf_ret_rdwen,
    input  logic                          oitf_ret_rdfpu,
    output logic                          oitf_ret_ena,
    output logic                          longp_wbck_o_valid,
    input  logic                          longp_wbck_o_ready,
    output logic [31:0]                   longp_wbck_o_wdat,
    output logic [4:0]                    longp_wbck_o_rdidx,
    output logic                          longp_wbck_o_rdfpu,
    output logic [4:0]                    longp_wbck_o_flags,
    output logic                          longp_excp_o_valid,
    input  logic                          longp_excp_o_ready,
    output logic                          longp_excp_o_src,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          stall_err
);

    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_STALL_W = $clog2(STALL_MAX + 1);
    localparam int c_ENT_W   = 41;

    // Entry layout: [40:9] wdat, [8:4] rdidx, [3] rdwen, [2] rdfpu, [1] err, [0] src
    logic [c_ENT_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic                 r_stall_err;

    logic                 w_lsu_hit;
    logic                 w_mdv_hit;
    logic                 w_mdv_lost;
    logic                 w_full;
    logic                 w_acc_ok;
    logic                 w_push;
    logic [c_ENT_W-1:0]   w_push_ent;
    logic [c_ENT_W-1:0]   w_head;
    logic                 w_head_vld;
    logic                 w_wbck_vld;
    logic                 w_excp_vld;
    logic                 w_silent;
    logic                 w_pop;
    logic                 w_stall_inc;

    // Only the unit holding the OITF head may retire; LSU wins a double hit.
    // Acceptance is also held off while in reset so no OITF entry is returned.
    assign w_lsu_hit   = lsu_i_valid & ~oitf_empty & (lsu_i_itag == oitf_ret_ptr);
    assign w_mdv_hit   = mdv_i_valid & ~oitf_empty & (mdv_i_itag == oitf_ret_ptr);
    assign w_mdv_lost  = w_lsu_hit;
    assign w_full      = (r_cnt == c_CNT_W'(FIFO_DEPTH));
    assign w_acc_ok    = ~w_full & ~rst;
    assign w_push      = (w_lsu_hit | w_mdv_hit) & w_acc_ok;
    assign lsu_i_ready = w_lsu_hit & w_acc_ok;
    assign mdv_i_ready = w_mdv_hit & ~w_mdv_lost & w_acc_ok;
    assign oitf_ret_ena = w_push;

    assign w_push_ent = w_lsu_hit
        ? {lsu_i_wdat, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_rdfpu, lsu_i_err, 1'b0}
        : {mdv_i_wdat, oitf_ret_rdidx, oitf_ret_rdwen, oitf_ret_rdfpu, mdv_i_err, 1'b1};

    // Head classification: error -> exception, rdwen -> write-back, else silent
    assign w_head     = r_mem[r_rptr];
    assign w_head_vld = (r_cnt != '0);
    assign w_excp_vld = w_head_vld & w_head[1];
    assign w_wbck_vld = w_head_vld & ~w_head[1] & w_head[3];
    assign w_silent   = w_head_vld & ~w_head[1] & ~w_head[3];
    assign w_pop      = (w_wbck_vld & longp_wbck_o_ready)
                      | (w_excp_vld & longp_excp_o_ready)
                      | w_silent;

    assign longp_wbck_o_valid = w_wbck_vld;
    assign longp_wbck_o_wdat  = w_head[40:9];
    assign longp_wbck_o_rdidx = w_head[8:4];
    assign longp_wbck_o_rdfpu = w_head[2];
    assign longp_wbck_o_flags = 5'd0;
    assign longp_excp_o_valid = w_excp_vld;
    assign longp_excp_o_src   = w_head[0];
    assign fifo_cnt           = r_cnt;
    assign stall_err          = r_stall_err;

    // Result storage; contents are don't-care until the slot is pushed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_ent;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // No-retirement watchdog: saturating counter with a sticky error flag
    assign w_stall_inc = ~oitf_empty & ~w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else begin
            if (!w_stall_inc) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != c_STALL_W'(STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_STALL_W'(1);
            end
            if (w_stall_inc && (r_stall_cnt == c_STALL_W'(STALL_MAX - 1))) begin
                r_stall_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_longpwbck_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_exu_longpwbck_sched
// Brief    : Directed + random bench for the long-pipe write-back scheduler,
//            compared cycle by cycle against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_exu_longpwbck_sched;

    localparam int ITAG_W     = 1;
    localparam int FIFO_DEPTH = 2;
    localparam int STALL_MAX  = 4;

    logic              clk;
    logic              rst;
    logic              lsu_i_valid;
    logic              lsu_i_ready;
    logic [31:0]       lsu_i_wdat;
    logic [ITAG_W-1:0] lsu_i_itag;
    logic              lsu_i_err;
    logic              mdv_i_valid;
    logic              mdv_i_ready;
    logic [31:0]       mdv_i_wdat;
    logic [ITAG_W-1:0] mdv_i_itag;
    logic              mdv_i_err;
    logic              oitf_empty;
    logic [ITAG_W-1:0] oitf_ret_ptr;
    logic [4:0]        oitf_ret_rdidx;
    logic              oitf_ret_rdwen;
    logic              oitf_ret_rdfpu;
    logic              oitf_ret_ena;
    logic              longp_wbck_o_valid;
    logic              longp_wbck_o_ready;
    logic [31:0]       longp_wbck_o_wdat;
    logic [4:0]        longp_wbck_o_rdidx;
    logic              longp_wbck_o_rdfpu;
    logic [4:0]        longp_wbck_o_flags;
    logic              longp_excp_o_valid;
    logic              longp_excp_o_ready;
    logic              longp_excp_o_src;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic              stall_err;

    e203_exu_longpwbck_sched #(
        .ITAG_W    (ITAG_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lsu_i_valid       (lsu_i_valid),
        .lsu_i_ready       (lsu_i_ready),
        .lsu_i_wdat        (lsu_i_wdat),
        .lsu_i_itag        (lsu_i_itag),
        .lsu_i_err         (lsu_i_err),
        .mdv_i_valid       (mdv_i_valid),
        .mdv_i_ready       (mdv_i_ready),
        .mdv_i_wdat        (mdv_i_wdat),
        .mdv_i_itag        (mdv_i_itag),
        .mdv_i_err         (mdv_i_err),
        .oitf_empty        (oitf_empty),
        .oitf_ret_ptr      (oitf_ret_ptr),
        .oitf_ret_rdidx    (oitf_ret_rdidx),
        .oitf_ret_rdwen    (oitf_ret_rdwen),
        .oitf_ret_rdfpu    (oitf_ret_rdfpu),
        .oitf_ret_ena      (oitf_ret_ena),
        .longp_wbck_o_valid(longp_wbck_o_valid),
        .longp_wbck_o_ready(longp_wbck_o_ready),
        .longp_wbck_o_wdat (longp_wbck_o_wdat),
        .longp_wbck_o_rdidx(longp_wbck_o_rdidx),
        .longp_wbck_o_rdfpu(longp_wbck_o_rdfpu),
        .longp_wbck_o_flags(longp_wbck_o_flags),
        .longp_excp_o_valid(longp_excp_o_valid),
        .longp_excp_o_ready(longp_excp_o_ready),
        .longp_excp_o_src  (longp_excp_o_src),
        .fifo_cnt          (fifo_cnt),
        .stall_err         (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: results waiting to retire, in retirement order
    typedef struct {
        logic [31:0] wdat;
        logic [4:0]  rdidx;
        logic        rdwen;
        logic        rdfpu;
        logic        err;
        logic        src;
    } ent_t;

    ent_t q[$];
    int   m_stall;
    bit   m_err;
    bit   m_push;
    bit   m_pop;
    bit   m_lhit;
    int   n_chk;
    int   n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        lsu_i_valid = 0; lsu_i_wdat = 0; lsu_i_itag = 0; lsu_i_err = 0;
        mdv_i_valid = 0; mdv_i_wdat = 0; mdv_i_itag = 0; mdv_i_err = 0;
        oitf_empty = 1; oitf_ret_ptr = 0; oitf_ret_rdidx = 0;
        oitf_ret_rdwen = 0; oitf_ret_rdfpu = 0;
        longp_wbck_o_ready = 1; longp_excp_o_ready = 1;
    endtask

    // Compare every output against the model at the falling edge, then work
    // out what the coming rising edge will do to the model.
    task automatic settle();
        bit full, mhit, wv, ev, sil;
        ent_t h;
        ent_t n;
        @(negedge clk);
        full   = (q.size() == FIFO_DEPTH);
        m_lhit = lsu_i_valid && !oitf_empty && (lsu_i_itag == oitf_ret_ptr);
        mhit   = mdv_i_valid && !oitf_empty && (mdv_i_itag == oitf_ret_ptr);
        m_push = (m_lhit || mhit) && !full;
        check("lsu_ready", lsu_i_ready, m_lhit && !full);
        check("mdv_ready", mdv_i_ready, mhit && !m_lhit && !full);
        check("ret_ena", oitf_ret_ena, m_push);
        check("fifo_cnt", fifo_cnt, q.size());
        check("stall_err", stall_err, m_err);
        check("flags", longp_wbck_o_flags, 0);
        wv = 0; ev = 0; sil = 0;
        if (q.size() > 0) begin
            h   = q[0];
            ev  = h.err;
            wv  = !h.err && h.rdwen;
            sil = !h.err && !h.rdwen;
            if (wv) begin
                check("wbck_wdat", longp_wbck_o_wdat, h.wdat);
                check("wbck_rdidx", longp_wbck_o_rdidx, h.rdidx);
                check("wbck_rdfpu", longp_wbck_o_rdfpu, h.rdfpu);
            end
            if (ev) check("excp_src", longp_excp_o_src, h.src);
        end
        check("wbck_valid", longp_wbck_o_valid, wv);
        check("excp_valid", longp_excp_o_valid, ev);
        m_pop = (wv && longp_wbck_o_ready) || (ev && longp_excp_o_ready) || sil;
        // state after the edge
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
            n.wdat  = m_lhit ? lsu_i_wdat : mdv_i_wdat;
            n.err   = m_lhit ? lsu_i_err : mdv_i_err;
            n.src   = !m_lhit;
            n.rdidx = oitf_ret_rdidx;
            n.rdwen = oitf_ret_rdwen;
            n.rdfpu = oitf_ret_rdfpu;
            q.push_back(n);
        end
        if (oitf_empty || m_push) m_stall = 0;
        else if (m_stall < STALL_MAX) m_stall++;
        if (m_stall == STALL_MAX) m_err = 1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        adv();
        rst = 0;
        q.delete();
        m_stall = 0;
        m_err = 0;
    endtask

    task automatic lsu_hit(input logic [31:0] d, input logic [4:0] rd, input logic [ITAG_W-1:0] tag);
        oitf_empty = 0; oitf_ret_ptr = tag; oitf_ret_rdidx = rd; oitf_ret_rdwen = 1;
        lsu_i_valid = 1; lsu_i_itag = tag; lsu_i_wdat = d;
    endtask

    initial begin
        n_chk = 0; n_err = 0; m_stall = 0; m_err = 0;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // reset state
        idle(); settle();
        check("rst_cnt", fifo_cnt, 0);
        check("rst_wbck_v", longp_wbck_o_valid, 0);
        check("rst_stall", stall_err, 0);
        adv();

        // single LSU result, 1-cycle latency to write-back
        idle(); lsu_hit(32'h1234_5678, 5'd5, 0); settle();
        check("t1_lsu_rdy", lsu_i_ready, 1);
        check("t1_ret_ena", oitf_ret_ena, 1);
        adv();
        idle(); settle();
        check("t1_wbck_v", longp_wbck_o_valid, 1);
        check("t1_wdat", longp_wbck_o_wdat, 32'h1234_5678);
        check("t1_rdidx", longp_wbck_o_rdidx, 5);
        adv();

        // out of order: MULDIV itag 1 must wait for LSU itag 0
        idle(); oitf_empty = 0; oitf_ret_ptr = 0; oitf_ret_rdwen = 1; oitf_ret_rdidx = 7;
        mdv_i_valid = 1; mdv_i_itag = 1; mdv_i_wdat = 32'hAAAA_0001; settle();
        check("t2_mdv_wait", mdv_i_ready, 0);
        adv();
        lsu_i_valid = 1; lsu_i_itag = 0; lsu_i_wdat = 32'h5555_0000; oitf_ret_rdidx = 3; settle();
        check("t2_lsu_rdy", lsu_i_ready, 1);
        check("t2_mdv_rdy0", mdv_i_ready, 0);
        adv();
        lsu_i_valid = 0; oitf_ret_ptr = 1; oitf_ret_rdidx = 7; settle();
        check("t2_mdv_rdy1", mdv_i_ready, 1);
        check("t2_first", longp_wbck_o_wdat, 32'h5555_0000);
        adv();
        idle(); settle();
        check("t2_second", longp_wbck_o_wdat, 32'hAAAA_0001);
        adv();

        // backpressure: fill, block third hit, pop without push
        idle(); lsu_hit(32'd1, 5'd1, 0); longp_wbck_o_ready = 0; cyc();
        lsu_hit(32'd2, 5'd2, 1); cyc();
        lsu_hit(32'd3, 5'd3, 0); settle();
        check("t3_cnt2", fifo_cnt, 2);
        check("t3_full_rdy", lsu_i_ready, 0);
        adv();
        longp_wbck_o_ready = 1; settle();
        check("t3_pop_only", lsu_i_ready, 0);
        adv();
        idle(); longp_wbck_o_ready = 0; settle();
        check("t3_cnt1", fifo_cnt, 1);
        adv();
        idle(); cyc();

        // error routing, then a silent entry
        idle(); lsu_hit(32'hDEAD_BEEF, 5'd9, 0); lsu_i_err = 1; cyc();
        idle(); longp_excp_o_ready = 0; settle();
        check("t4_excp_v", longp_excp_o_valid, 1);
        check("t4_src", longp_excp_o_src, 0);
        check("t4_no_wbck", longp_wbck_o_valid, 0);
        adv();
        idle(); cyc();
        idle(); lsu_hit(32'h0000_0077, 5'd4, 0); oitf_ret_rdwen = 0; cyc();
        idle(); settle();
        check("t4_sil_wv", longp_wbck_o_valid, 0);
        check("t4_sil_ev", longp_excp_o_valid, 0);
        adv();
        idle(); settle();
        check("t4_sil_gone", fifo_cnt, 0);
        adv();

        // stall timeout after STALL_MAX idle cycles with a busy OITF
        idle(); oitf_empty = 0;
        repeat (STALL_MAX - 1) cyc();
        settle();
        check("t5_not_yet", stall_err, 0);
        adv();
        settle();
        check("t5_set", stall_err, 1);
        adv();
        lsu_hit(32'd8, 5'd8, 0); cyc();
        idle(); settle();
        check("t5_sticky", stall_err, 1);
        adv();
        do_reset();
        idle(); settle();
        check("t5_cleared", stall_err, 0);
        adv();

        // reset with a full buffer
        idle(); longp_wbck_o_ready = 0; lsu_hit(32'd10, 5'd10, 0); cyc();
        lsu_hit(32'd11, 5'd11, 1); cyc();
        idle(); longp_wbck_o_ready = 0; settle();
        check("t6_full", fifo_cnt, 2);
        adv();
        do_reset();
        idle(); settle();
        check("t6_cnt0", fifo_cnt, 0);
        check("t6_wv0", longp_wbck_o_valid, 0);
        check("t6_ev0", longp_excp_o_valid, 0);
        adv();

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                lsu_i_valid        = ($urandom_range(0, 2) != 0);
                lsu_i_itag         = ITAG_W'($urandom);
                lsu_i_wdat         = $urandom;
                lsu_i_err          = ($urandom_range(0, 5) == 0);
                mdv_i_valid        = ($urandom_range(0, 2) != 0);
                mdv_i_itag         = ITAG_W'($urandom);
                mdv_i_wdat         = $urandom;
                mdv_i_err          = ($urandom_range(0, 7) == 0);
                oitf_empty         = ($urandom_range(0, 4) == 0);
                oitf_ret_ptr       = ITAG_W'($urandom);
                oitf_ret_rdidx     = 5'($urandom);
                oitf_ret_rdwen     = ($urandom_range(0, 3) != 0);
                oitf_ret_rdfpu     = 1'($urandom);
                longp_wbck_o_ready = ($urandom_range(0, 2) != 0);
                longp_excp_o_ready = ($urandom_range(0, 1) != 0);
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
